spi_receiver: RTL
=================

Name: spi_receiver

Overview:
SPI slave (mode 0, CPOL=0/CPHA=0, MSB first) sitting directly upstream of the shader core inside tiny_shader_top. It turns host SPI transactions into write strobes for the shader instruction memory and serves read-back of that memory over MISO. The SPI pins are asynchronous to clk_i; all logic runs in the clk_i domain after synchronisation.

Parameters:
NUM_INSTR, 16, number of instruction memory entries; address wraps at NUM_INSTR-1
INSTR_WIDTH, 8, instruction width in bits; fixed to 8 (one SPI byte per instruction)
ADDR_WIDTH, $clog2(NUM_INSTR), instruction address width (derived, not overridden)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous reset, active low
spi_sclk_i  input  1  SPI clock, asynchronous; max frequency clk_i/4
spi_mosi_i  input  1  SPI data in, asynchronous
spi_cs_i  input  1  SPI chip select, active low, asynchronous
spi_miso_o  output  1  SPI data out
instr_we_o  output  1  one-cycle write strobe to instruction memory
instr_addr_o  output  ADDR_WIDTH  write/read address to instruction memory
instr_data_o  output  INSTR_WIDTH  write data
instr_rdata_i  input  INSTR_WIDTH  combinational read data for instr_addr_o, valid in the same cycle

Behaviour:
- Reset: asynchronous and active low on rst_ni. All flops clear. spi_miso_o=0, instr_we_o=0, instr_addr_o=0, instr_data_o=0, state=IDLE, bit_cnt=0.
- Synchronisation: sclk, mosi and cs each pass through 2-flop synchronisers. The sclk rising/falling edge pulse comes from a third flop. Latency from pin to internal event is 3 clk_i cycles.
- bit_cnt (3 bit) counts rising SCLK edges within a byte. On each rising edge the shift_in register takes {shift_in[6:0], mosi}. On the 8th edge the byte is complete: byte_done pulses and bit_cnt wraps to 0.
- States:
  - IDLE: cs high. Transition to CMD when synced cs goes low. addr=0, bit_cnt=0 on entry.
  - CMD: on byte_done, 0x00 goes to WRITE, 0x01 goes to READ (see below), any other value goes to IGNORE.
  - WRITE: on byte_done, the cycle after byte_done has instr_we_o=1, instr_addr_o=addr, instr_data_o=byte; then addr increments, wrapping NUM_INSTR-1 -> 0.
  - READ: on the cycle of byte_done (this includes the cmd byte that enters READ), shift_out is loaded with instr_rdata_i at the current addr, then addr increments with wrap.
  - IGNORE: consumes bytes with no side effects.
- MISO rules:
  - spi_miso_o = shift_out[7] while in READ, else 0.
  - On a falling SCLK edge with bit_cnt != 0, shift_out shifts left. A falling edge with bit_cnt == 0 (the one right after a load) does not shift, so bit7 stays valid for the next rising edge.
- CS rules:
  - cs deassert (synced high) in any state returns to IDLE next cycle. A partial byte is discarded and no write is issued for it.
  - If a write strobe is pending in the same cycle as cs deassert, it still issues.
- A byte_done pulse and a cs rising edge in the same cycle: the byte is processed first, then IDLE.
- instr_we_o is never high for more than 1 consecutive cycle. instr_addr_o holds its value between accesses.
- Reset asserted mid-transaction: all state clears immediately. The next transaction requires a fresh cs falling edge after the synced cs has been seen high.

Decomposition:
- Shared package shader_pkg holds:
  - spi_cmd_t enum (CMD_WRITE_MEM=8'h00, CMD_READ_MEM=8'h01)
  - spi_state_t enum (IDLE, CMD, WRITE, READ, IGNORE)
  - NUM_INSTR default constant
- One natural sub-module: sync_2ff (parameterised width, 2-flop synchroniser), instantiated once for {sclk, mosi, cs}.

Test Plan:
- Write 3 bytes: cs low, send 0x00, 0xA5, 0x3C, 0xFF, cs high -> three we pulses at addr 0,1,2 with data 0xA5, 0x3C, 0xFF. No further pulses.
- Wrap: send 0x00 then 17 bytes 0x00..0x10 with NUM_INSTR=16 -> 17th write lands at addr 0 with data 0x10.
- Read-back: memory model preloaded with addr0=0x81, addr1=0x7E; send 0x01 then 2 dummy bytes -> MISO bits sampled on SCLK rising give 0x81, then 0x7E. MISO is 0 during the cmd byte.
- Abort: cs low, 0x00, then 5 bits of 0xFF, cs high -> no we pulse. Next transaction 0x00, 0x11 writes 0x11 to addr 0.
- Unknown command: 0x42, 0x55, 0x66 -> no we pulse and MISO stays 0 throughout.
- Reset mid-write: assert rst_ni low after 4 data bits -> all outputs 0 immediately. After release, a full write of 0x00, 0x99 writes 0x99 to addr 0.

Source files
------------

// File: rtl/shader_pkg.sv
// Shared types and defaults for the tiny shader SPI front end.
package shader_pkg;

  localparam int NUM_INSTR_DEF = 16;

  typedef enum logic [7:0] {
    CMD_WRITE_MEM = 8'h00,
    CMD_READ_MEM  = 8'h01
  } spi_cmd_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WRITE  = 3'd2,
    READ   = 3'd3,
    IGNORE = 3'd4
  } spi_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing asynchronous pins into the clk_i domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability filter chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= d_i;
      sync_r <= meta_r;
    end
  end

  assign q_o = sync_r;

endmodule

// File: rtl/spi_receiver.sv
// SPI mode-0 slave turning host transactions into instruction memory writes
// and serving memory read-back on MISO.
module spi_receiver
  import shader_pkg::*;
#(
  parameter  int NUM_INSTR   = NUM_INSTR_DEF,
  parameter  int INSTR_WIDTH = 8,
  localparam int ADDR_WIDTH  = $clog2(NUM_INSTR)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   spi_sclk_i,
  input  logic                   spi_mosi_i,
  input  logic                   spi_cs_i,
  output logic                   spi_miso_o,
  output logic                   instr_we_o,
  output logic [ADDR_WIDTH-1:0]  instr_addr_o,
  output logic [INSTR_WIDTH-1:0] instr_data_o,
  input  logic [INSTR_WIDTH-1:0] instr_rdata_i
);

  logic [2:0]             pins_sync_s;
  logic                   sclk_sync_s, mosi_sync_s, cs_sync_s;
  logic                   sclk_d_r, cs_d_r;
  logic                   sclk_rise_s, sclk_fall_s, cs_fall_s;
  logic [2:0]             bit_cnt_r;
  logic [INSTR_WIDTH-1:0] shift_in_r, shift_out_r, shift_out_next_s, byte_val_s;
  logic                   byte_done_s, load_rd_s, wr_s;
  logic [ADDR_WIDTH-1:0]  addr_r, addr_inc_s;
  logic                   we_r, miso_r;
  logic [INSTR_WIDTH-1:0] data_r;
  spi_state_t             state_r, state_next_s, fsm_next_s;

  sync_2ff #(.WIDTH(3)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({spi_sclk_i, spi_mosi_i, spi_cs_i}),
    .q_o    (pins_sync_s)
  );

  assign sclk_sync_s = pins_sync_s[2];
  assign mosi_sync_s = pins_sync_s[1];
  assign cs_sync_s   = pins_sync_s[0];

  // cs_d_r clears on reset, so a new transaction needs cs seen high first.
  assign sclk_rise_s = sclk_sync_s & ~sclk_d_r;
  assign sclk_fall_s = ~sclk_sync_s & sclk_d_r;
  assign cs_fall_s   = ~cs_sync_s & cs_d_r;

  assign byte_val_s  = {shift_in_r[INSTR_WIDTH-2:0], mosi_sync_s};
  assign byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7) && (state_r != IDLE);
  assign wr_s        = byte_done_s && (state_r == WRITE);
  assign load_rd_s   = byte_done_s && ((state_r == READ) ||
                       ((state_r == CMD) && (byte_val_s == CMD_READ_MEM)));
  assign addr_inc_s  = (addr_r == ADDR_WIDTH'(NUM_INSTR - 1)) ? '0 : addr_r + ADDR_WIDTH'(1);

  // Next-state decode; cs deassert overrides after the byte is consumed.
  always_comb begin
    fsm_next_s   = state_r;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) fsm_next_s = CMD;
        else           fsm_next_s = IDLE;
      end
      CMD: begin
        if (!byte_done_s)                        fsm_next_s = CMD;
        else if (byte_val_s == CMD_WRITE_MEM)    fsm_next_s = WRITE;
        else if (byte_val_s == CMD_READ_MEM)     fsm_next_s = READ;
        else                                     fsm_next_s = IGNORE;
      end
      WRITE:   fsm_next_s = WRITE;
      READ:    fsm_next_s = READ;
      IGNORE:  fsm_next_s = IGNORE;
      default: fsm_next_s = IDLE;
    endcase
    if (cs_sync_s) state_next_s = IDLE;
    else           state_next_s = fsm_next_s;
  end

  // Read shifter: the falling edge right after a load keeps bit 7 on MISO.
  always_comb begin
    shift_out_next_s = shift_out_r;
    if (load_rd_s)
      shift_out_next_s = instr_rdata_i;
    else if (sclk_fall_s && (bit_cnt_r != 3'd0))
      shift_out_next_s = {shift_out_r[INSTR_WIDTH-2:0], 1'b0};
    else
      shift_out_next_s = shift_out_r;
  end

  // State register and pin edge history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= IDLE;
      sclk_d_r <= 1'b0;
      cs_d_r   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      sclk_d_r <= sclk_sync_s;
      cs_d_r   <= cs_sync_s;
    end
  end

  // Byte assembly; a partial byte is dropped when cs goes high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_r  <= 3'd0;
      shift_in_r <= '0;
    end else if ((state_r == IDLE) || cs_sync_s) begin
      bit_cnt_r  <= 3'd0;
      shift_in_r <= '0;
    end else if (sclk_rise_s) begin
      bit_cnt_r  <= bit_cnt_r + 3'd1;
      shift_in_r <= byte_val_s;
    end else begin
      bit_cnt_r  <= bit_cnt_r;
      shift_in_r <= shift_in_r;
    end
  end

  // Memory interface: address advances after each write strobe or read load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_r      <= '0;
      we_r        <= 1'b0;
      data_r      <= '0;
      shift_out_r <= '0;
      miso_r      <= 1'b0;
    end else begin
      we_r        <= wr_s;
      data_r      <= wr_s ? byte_val_s : data_r;
      shift_out_r <= shift_out_next_s;
      miso_r      <= (state_next_s == READ) ? shift_out_next_s[INSTR_WIDTH-1] : 1'b0;
      if (we_r || load_rd_s)   addr_r <= addr_inc_s;
      else if (state_r == IDLE) addr_r <= '0;
      else                      addr_r <= addr_r;
    end
  end

  assign spi_miso_o   = miso_r;
  assign instr_we_o   = we_r;
  assign instr_addr_o = addr_r;
  assign instr_data_o = data_r;

endmodule
